// File: rtl/conv2d_strided_shift.sv
// Strided "valid" 2-D convolution with shift-quantised weights (+/-2^(+/-s)).
// Input map and result map live in internal RAMs; kernel codes come from an external sync ROM.
module conv2d_strided_shift #(
    parameter int INT_W   = 10,
    parameter int FRAC_W  = 10,
    parameter int IN_SIZE = 30,
    parameter int KERNEL  = 3,
    parameter int STRIDE  = 3,
    parameter int KW      = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [INT_W+FRAC_W-1:0]   in_data,
    output logic [3:0]                kernel_addr,
    input  logic [KW-1:0]             kernel_data,
    input  logic [9:0]                out_addr,
    output logic [INT_W+FRAC_W-1:0]   out_data,
    output logic                      busy,
    output logic                      done
);

    localparam int DATA_W   = INT_W + FRAC_W;
    localparam int ACC_W    = DATA_W + 16;
    localparam int OUT_SIZE = (IN_SIZE - KERNEL) / STRIDE + 1;
    localparam int IN_PIX   = IN_SIZE * IN_SIZE;
    localparam int OUT_PIX  = OUT_SIZE * OUT_SIZE;
    localparam int IAW      = (IN_PIX   > 1) ? $clog2(IN_PIX)   : 1;
    localparam int OAW      = (OUT_PIX  > 1) ? $clog2(OUT_PIX)  : 1;
    localparam int OCW      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int KCW      = (KERNEL   > 1) ? $clog2(KERNEL)   : 1;

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_MAC   = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [2:0]              state_q, state_d;
    logic [IAW-1:0]          load_cnt_q, load_cnt_d;
    logic [OCW-1:0]          oi_q, oi_d, oj_q, oj_d;
    logic [KCW-1:0]          ki_q, ki_d, kj_q, kj_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]              kaddr_q, kaddr_d;
    logic [IAW-1:0]          pix_addr_q, pix_addr_d;

    logic [DATA_W-1:0]       in_ram  [IN_PIX];
    logic [DATA_W-1:0]       out_ram [OUT_PIX];
    logic [DATA_W-1:0]       pix_rd_q;
    logic [DATA_W-1:0]       out_rd_q;

    logic                    in_we;
    logic                    out_we;
    logic [OAW-1:0]          out_waddr;
    logic [DATA_W-1:0]       sat_val;

    logic signed [ACC_W-1:0] pix_ext;
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] term;
    logic [KW-3:0]           shamt;

    // Tap contribution: sign-extend, shift (arithmetic right floors), optionally negate.
    always_comb begin
        pix_ext = {{(ACC_W-DATA_W){pix_rd_q[DATA_W-1]}}, pix_rd_q};
        shamt   = kernel_data[KW-3:0];
        shifted = kernel_data[KW-2] ? (pix_ext >>> shamt) : (pix_ext <<< shamt);
        term    = kernel_data[KW-1] ? -shifted : shifted;
    end

    always_comb begin
        if (acc_q > SAT_MAX) begin
            sat_val = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (acc_q < SAT_MIN) begin
            sat_val = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_val = acc_q[DATA_W-1:0];
        end
    end

    assign out_waddr = OAW'(OUT_SIZE) * OAW'(oi_q) + OAW'(oj_q);

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        oi_d       = oi_q;
        oj_d       = oj_q;
        ki_d       = ki_q;
        kj_d       = kj_q;
        acc_d      = acc_q;
        kaddr_d    = kaddr_q;
        pix_addr_d = pix_addr_q;
        in_we      = 1'b0;
        out_we     = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    in_we      = 1'b1;
                    load_cnt_d = load_cnt_q + IAW'(1);
                    if (load_cnt_q == IAW'(IN_PIX - 1)) begin
                        load_cnt_d = '0;
                        state_d    = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                pix_addr_d = (IAW'(STRIDE) * IAW'(oi_q) + IAW'(ki_q)) * IAW'(IN_SIZE)
                           + IAW'(STRIDE) * IAW'(oj_q) + IAW'(kj_q);
                kaddr_d    = 4'(KERNEL) * 4'(ki_q) + 4'(kj_q);
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d   = acc_q + term;
                state_d = S_ADDR;
                if (kj_q == KCW'(KERNEL - 1)) begin
                    kj_d = '0;
                    if (ki_q == KCW'(KERNEL - 1)) begin
                        ki_d    = '0;
                        state_d = S_WRITE;
                    end else begin
                        ki_d = ki_q + KCW'(1);
                    end
                end else begin
                    kj_d = kj_q + KCW'(1);
                end
            end
            S_WRITE: begin
                out_we  = 1'b1;
                acc_d   = '0;
                state_d = S_ADDR;
                if (oj_q == OCW'(OUT_SIZE - 1)) begin
                    oj_d = '0;
                    if (oi_q == OCW'(OUT_SIZE - 1)) begin
                        oi_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        oi_d = oi_q + OCW'(1);
                    end
                end else begin
                    oj_d = oj_q + OCW'(1);
                end
            end
            S_DONE: begin
                // load_cnt is parked at 0 here, so this write lands on pixel 0
                if (in_valid) begin
                    in_we      = 1'b1;
                    load_cnt_d = IAW'(1);
                    state_d    = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_LOAD;
            load_cnt_q <= '0;
            oi_q       <= '0;
            oj_q       <= '0;
            ki_q       <= '0;
            kj_q       <= '0;
            acc_q      <= '0;
            kaddr_q    <= '0;
            pix_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            oi_q       <= oi_d;
            oj_q       <= oj_d;
            ki_q       <= ki_d;
            kj_q       <= kj_d;
            acc_q      <= acc_d;
            kaddr_q    <= kaddr_d;
            pix_addr_q <= pix_addr_d;
        end
    end

    // RAMs carry no reset so their contents survive an abort.
    always_ff @(posedge clk) begin
        if (in_we) begin
            in_ram[load_cnt_q] <= in_data;
        end
        pix_rd_q <= in_ram[pix_addr_q];
    end

    always_ff @(posedge clk) begin
        if (out_we) begin
            out_ram[out_waddr] <= sat_val;
        end
        if (state_q == S_DONE && out_addr < 10'(OUT_PIX)) begin
            out_rd_q <= out_ram[out_addr[OAW-1:0]];
        end
    end

    assign kernel_addr = kaddr_q;
    assign out_data    = out_rd_q;
    assign busy        = (state_q == S_ADDR) || (state_q == S_WAIT) ||
                         (state_q == S_MAC)  || (state_q == S_WRITE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_conv2d_strided_shift.sv
// Scoreboard bench for conv2d_strided_shift: a behavioural convolution model queues expected
// results, and a negedge monitor compares them against the readout port.
module tb_conv2d_strided_shift;

    localparam int IN_SIZE  = 30;
    localparam int KSZ      = 3;
    localparam int STR      = 3;
    localparam int OUT_SIZE = 10;
    localparam int NIN      = IN_SIZE * IN_SIZE;
    localparam int NOUT     = OUT_SIZE * OUT_SIZE;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [19:0] in_data;
    logic [3:0]  kernel_addr;
    logic [5:0]  kernel_data;
    logic [9:0]  out_addr;
    logic [19:0] out_data;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    conv2d_strided_shift #(
        .INT_W(10), .FRAC_W(10), .IN_SIZE(IN_SIZE), .KERNEL(KSZ), .STRIDE(STR), .KW(6)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .kernel_addr(kernel_addr), .kernel_data(kernel_data),
        .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
    );

    logic [5:0]  rom [16];
    always @(posedge clk) kernel_data <= rom[kernel_addr];

    logic [19:0] img [NIN];
    logic [19:0] exp_out [NOUT];
    logic [19:0] sb_q [$];
    int          sb_a [$];
    logic        rd_req = 1'b0;
    logic        rd_vld = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;

    always @(posedge clk) rd_vld <= rd_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Reference: direct sum over each strided window, weights as exact powers of two with floor.
    function automatic void compute_expected();
        for (int oi = 0; oi < OUT_SIZE; oi++) begin
            for (int oj = 0; oj < OUT_SIZE; oj++) begin
                longint s = 0;
                for (int ki = 0; ki < KSZ; ki++) begin
                    for (int kj = 0; kj < KSZ; kj++) begin
                        logic [5:0] c;
                        longint p, d, t;
                        int amt;
                        c   = rom[ki*KSZ + kj];
                        p   = longint'($signed(img[(STR*oi + ki)*IN_SIZE + STR*oj + kj]));
                        amt = int'(c[3:0]);
                        d   = longint'(1) << amt;
                        if (c[4]) begin
                            t = p / d;
                            if ((p % d) != 0 && p < 0) t = t - 1;
                        end else begin
                            t = p * d;
                        end
                        if (c[5]) t = -t;
                        s += t;
                    end
                end
                if (s > 524287)  s = 524287;
                if (s < -524288) s = -524288;
                exp_out[oi*OUT_SIZE + oj] = s[19:0];
            end
        end
    endfunction

    task automatic set_codes(input logic [5:0] c);
        for (int i = 0; i < 16; i++) rom[i] = c;
    endtask

    task automatic rand_codes();
        for (int i = 0; i < 16; i++) begin
            logic right;
            right  = 1'($urandom_range(1));
            rom[i] = {1'($urandom_range(1)), right,
                      right ? 4'($urandom_range(15)) : 4'($urandom_range(12))};
        end
    endtask

    task automatic fill_img(input logic [19:0] v);
        for (int i = 0; i < NIN; i++) img[i] = v;
    endtask

    task automatic load_image(input string tag, input bit from_done);
        for (int i = 0; i < NIN; i++) begin
            if (i > 0 && $urandom_range(7) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = img[i];
            @(posedge clk); #1;
            if (i == 0 && from_done) chk({tag, " done_drop"}, 32'(done), 32'd0);
        end
        in_valid = 1'b0;
        chk({tag, " busy_rise"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        bit busy_ok = 1'b1;
        while (!done && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            if (!done && !busy) busy_ok = 1'b0;
        end
        chk({tag, " latency"}, 32'(cyc), 32'd2800);
        chk({tag, " busy_held"}, 32'(busy_ok), 32'd1);
        chk({tag, " busy_fall"}, 32'(busy), 32'd0);
    endtask

    // known_en: compare every output against one fixed value instead of the model.
    task automatic readout(input string tag, input bit known_en, input logic [19:0] known);
        int order [NOUT];
        for (int i = 0; i < NOUT; i++) order[i] = i;
        for (int i = NOUT - 1; i > 0; i--) begin
            int j, tmp;
            j = $urandom_range(i);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < NOUT; i++) begin
            sb_q.push_back(known_en ? known : exp_out[order[i]]);
            sb_a.push_back(order[i]);
            out_addr = 10'(order[i]);
            rd_req   = 1'b1;
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            out_addr = 10'(NOUT + $urandom_range(1023 - NOUT));
            @(posedge clk); #1;
        end
        sb_q.push_back(known_en ? known : exp_out[NOUT-1]);
        sb_a.push_back(NOUT - 1);
        out_addr = 10'(NOUT - 1);
        rd_req   = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk({tag, " sb_drain"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        sb_a.delete();
    endtask

    task automatic run(input string tag, input bit from_done, input bit known_en, input logic [19:0] known);
        load_image(tag, from_done);
        wait_done(tag);
        compute_expected();
        readout(tag, known_en, known);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rd_vld) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_underflow: output presented with nothing expected");
                end else begin
                    logic [19:0] e;
                    int a;
                    e = sb_q.pop_front();
                    a = sb_a.pop_front();
                    chk($sformatf("out[%0d]", a), 32'(out_data), 32'(e));
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        out_addr = '0;
        set_codes(6'b000000);
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst kaddr", 32'(kernel_addr), 32'd0);
        reset = 1'b0;

        fill_img(20'h00400);
        set_codes(6'b000000);
        run("t1", 1'b0, 1'b1, 20'h02400);

        set_codes(6'b100000);
        run("t2", 1'b1, 1'b1, 20'hFDC00);

        set_codes(6'b010001);
        run("t3a", 1'b1, 1'b1, 20'h01200);
        set_codes(6'b010000);
        run("t3b", 1'b1, 1'b1, 20'h02400);

        fill_img(20'h7FFFF);
        set_codes(6'b000100);
        run("t4a", 1'b1, 1'b1, 20'h7FFFF);
        set_codes(6'b100100);
        run("t4b", 1'b1, 1'b1, 20'h80000);

        for (int i = 0; i < NIN; i++) img[i] = 20'(i * 1024);
        set_codes(6'b011111);
        rom[4] = 6'b000000;
        run("t5", 1'b1, 1'b0, '0);

        fill_img(20'h00400);
        set_codes(6'b000000);
        load_image("t6abort", 1'b1);
        repeat (1000) @(posedge clk);
        #1;
        chk("t6 busy_mid", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6 rst busy", 32'(busy), 32'd0);
        chk("t6 rst done", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("t6 rst busy_edge", 32'(busy), 32'd0);
        chk("t6 rst done_edge", 32'(done), 32'd0);
        reset = 1'b0;
        run("t6reload", 1'b0, 1'b1, 20'h02400);

        for (int i = 0; i < NIN; i++) img[i] = 20'($urandom);
        rand_codes();
        run("t6second", 1'b1, 1'b0, '0);

        for (int i = 0; i < NIN; i++) img[i] = 20'($urandom);
        rand_codes();
        run("rand", 1'b1, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
